// File: rtl/fft_mult_sched.sv
// fft_mult_sched: four-requester round-robin scheduler in front of one
// shift-add multiplier.  A granted WIDTH x WIDTH unsigned multiply runs
// one bit per cycle.  The product and done_id are registered outputs.
//
// Optional feature: define FFT_MULT_SCHED_EARLY_EN to finish an operation
// as soon as the remaining multiplier bits are all zero.  The product is
// the same either way; only the latency changes.
//
// Handshake: a requester raises req[i] and holds it, with stable operands,
// until it sees gnt[i] (a one-cycle pulse).  Requests are sampled only
// while idle, so a request raised during an operation waits, not lost.
// done is a one-cycle pulse; product stays valid until the next done.
module fft_mult_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     a2,
    input  logic [WIDTH-1:0]     a3,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     b1,
    input  logic [WIDTH-1:0]     b2,
    input  logic [WIDTH-1:0]     b3,
    input  logic                 flush,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_id,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   areg;
    logic [2*WIDTH-1:0] breg;
    logic [2*WIDTH-1:0] acc;
    logic [3:0]         cnt;
    logic [1:0]         last_winner;
    logic [1:0]         owner;

    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] acc_next;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_winner;
        cand      = last_winner;
        for (int k = 1; k <= 4; k++) begin
            cand = last_winner + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        a_sel = a0;
        b_sel = b0;
        case (win_idx)
            2'd0: begin a_sel = a0; b_sel = b0; end
            2'd1: begin a_sel = a1; b_sel = b1; end
            2'd2: begin a_sel = a2; b_sel = b2; end
            2'd3: begin a_sel = a3; b_sel = b3; end
            default: begin a_sel = a0; b_sel = b0; end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current bit is set.
    always_comb begin
        acc_next = areg[0] ? (acc + breg) : acc;
    end

    // Scheduler FSM, multiplier datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= 2'd0;
            product     <= '0;
            acc         <= '0;
            areg        <= '0;
            breg        <= '0;
            cnt         <= 4'd0;
            last_winner <= 2'd3;
            owner       <= 2'd0;
        end else begin
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= 2'd0;
            case (state)
                IDLE: begin
                    if (!flush && win_found) begin
                        last_winner <= win_idx;
                        owner       <= win_idx;
                        areg        <= a_sel;
                        breg        <= {{WIDTH{1'b0}}, b_sel};
                        acc         <= '0;
                        cnt         <= 4'd0;
                        gnt         <= NREQ'(1) << win_idx;
                        busy        <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`ifdef FFT_MULT_SCHED_EARLY_EN
                    else if (areg == '0) begin
                        // No multiplier bits left: acc already holds the product.
                        product <= acc;
                        done    <= 1'b1;
                        done_id <= owner;
                        state   <= DONE;
                    end
`endif
                    else begin
                        acc  <= acc_next;
                        areg <= areg >> 1;
                        breg <= breg << 1;
                        cnt  <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            product <= acc_next;
                            done    <= 1'b1;
                            done_id <= owner;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_mult_sched.sv
// Bench for fft_mult_sched: table of single-requester multiplies, then
// fairness, flush and mid-operation reset sequences.  Expected products
// go to a queue at grant time and are compared when done pulses.
module tb_fft_mult_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] a0 = 0, a1 = 0, a2 = 0, a3 = 0;
    logic [15:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0;
    logic        flush = 1'b0;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [31:0] product;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];
    logic [31:0] last_p = 32'd0;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_p;
    } vec_t;
    vec_t vecs[10];

    fft_mult_sched #(.NREQ(4), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .flush(flush), .gnt(gnt), .busy(busy), .done(done),
        .done_id(done_id), .product(product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 34'd1, 34'd0);
            end else begin
                check("done_result", {done_id, product}, exp_q.pop_front());
            end
        end
    end

    function automatic int exp_lat(input logic [15:0] a);
        int msb;
        msb = -1;
        for (int i = 0; i < 16; i++) if (a[i]) msb = i;
`ifdef FFT_MULT_SCHED_EARLY_EN
        if (msb < 0) return 1;
        return (msb + 2 > 16) ? 16 : msb + 2;
`else
        return (msb > 99) ? 0 : 16;
`endif
    endfunction

    task automatic set_ops(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b);
        case (id)
            2'd0: begin a0 = a; b0 = b; end
            2'd1: begin a1 = a; b1 = b; end
            2'd2: begin a2 = a; b2 = b; end
            default: begin a3 = a; b3 = b; end
        endcase
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p);
        logic ok;
        int   g;
        set_ops(id, a, b);
        req = 4'd1 << id;
        wait_gnt(ok);
        check("gnt_seen", {33'd0, ok}, 34'd1);
        req = 4'd0;
        if (ok) begin
            g = cyc;
            check("gnt_onehot", {30'd0, gnt}, {30'd0, 4'd1 << id});
            check("busy_after_gnt", {33'd0, busy}, 34'd1);
            exp_q.push_back({id, exp_p});
            wait_done(ok);
            check("done_seen", {33'd0, ok}, 34'd1);
            if (ok) begin
                check("latency", 34'(cyc - g), 34'(exp_lat(a)));
                @(negedge clk);
                check("done_one_cycle", {33'd0, done}, 34'd0);
                check("idle_after_done", {33'd0, busy}, 34'd0);
                last_p = exp_p;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic ok;
        int   prev_g;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 34'd0);
        check("rst_busy", {33'd0, busy}, 34'd0);
        check("rst_done", {33'd0, done}, 34'd0);
        check("rst_done_id", {32'd0, done_id}, 34'd0);
        check("rst_product", {2'd0, product}, 34'd0);
        rst_n = 1'b1;

        // Table of single multiplies, including the 0 / 0xFFFF extremes.
        vecs[0] = '{2'd0, 16'd3,     16'd5,     32'd15};
        vecs[1] = '{2'd2, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
        vecs[2] = '{2'd1, 16'h0000,  16'h1234,  32'h0000_0000};
        vecs[3] = '{2'd0, 16'h0001,  16'h1234,  32'h0000_1234};
        vecs[4] = '{2'd3, 16'hFFFF,  16'h0000,  32'h0000_0000};
        vecs[5] = '{2'd1, 16'h8000,  16'h0002,  32'h0001_0000};
        vecs[6] = '{2'd2, 16'h0100,  16'h1234,  32'h0012_3400};
        vecs[7] = '{2'd3, 16'h00FF,  16'h0101,  32'h0000_FFFF};
        for (int i = 8; i < 10; i++) begin
            vecs[i].id    = 2'(i);
            vecs[i].a     = 16'($urandom_range(0, 65535));
            vecs[i].b     = 16'($urandom_range(0, 65535));
            vecs[i].exp_p = {16'd0, vecs[i].a} * {16'd0, vecs[i].b};
        end
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_p);
        end

        // Fairness: all four requesting after reset -> 0,1,2,3, 18 cycles apart.
        do_reset();
        for (int k = 0; k < 4; k++) set_ops(2'(k), 16'h8001 + 16'(k), 16'(k + 1));
        req = 4'b1111;
        prev_g = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(ok);
            check("fair_gnt_seen", {33'd0, ok}, 34'd1);
            check("fair_order", {30'd0, gnt}, {30'd0, 4'd1 << k});
            if (k > 0) check("fair_spacing", 34'(cyc - prev_g), 34'd18);
            prev_g = cyc;
            exp_q.push_back({2'(k), (32'h8001 + 32'(k)) * 32'(k + 1)});
            req[k] = 1'b0;
        end
        wait_done(ok);
        check("fair_last_done", {33'd0, ok}, 34'd1);
        last_p = 32'h8004 * 32'd4;
        @(negedge clk);

        // Flush at E8 of a1=7, b1=9: no done, product keeps prior value.
        set_ops(2'd1, 16'd7, 16'd9);
        req = 4'b0010;
        wait_gnt(ok);
        check("flush_gnt", {30'd0, gnt}, 34'b0010);
        req = 4'd0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {33'd0, busy}, 34'd0);
        check("flush_done", {33'd0, done}, 34'd0);
        check("flush_product", {2'd0, product}, {2'd0, last_p});
        repeat (12) @(negedge clk);
        check("flush_product_hold", {2'd0, product}, {2'd0, last_p});

        // Flush while idle blocks arbitration for that edge.
        set_ops(2'd0, 16'd3, 16'd5);
        req = 4'b0001;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("idle_flush_gnt", {30'd0, gnt}, 34'd0);
        check("idle_flush_busy", {33'd0, busy}, 34'd0);
        run_op(2'd0, 16'd3, 16'd5, 32'd15);

        // Reset at E5 of an op: outputs clear at once, no done, then 3 wins.
        set_ops(2'd2, 16'h1234, 16'h5678);
        req = 4'b0100;
        wait_gnt(ok);
        check("rst_mid_gnt", {30'd0, gnt}, 34'b0100);
        req = 4'd0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {33'd0, busy}, 34'd0);
        check("async_rst_product", {2'd0, product}, 34'd0);
        check("async_rst_done", {33'd0, done}, 34'd0);
        check("async_rst_gnt", {30'd0, gnt}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd3, 16'h00AB, 16'h00CD, 32'h00AB * 32'h00CD);

        repeat (5) @(negedge clk);
        check("queue_drained", 34'(exp_q.size()), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fft_mult_sched.md
FFT_MULT_SCHED -- requirements
Module: fft_mult_sched

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters (fixed at 4 in this revision); WIDTH, 16, operand width.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port req  input  4  per-requester multiply request, level, held until the matching gnt bit is seen.
REQ-005 Port a0..a3, b0..b3  input  16 each  unsigned operands per requester, stable while that req is high.
REQ-006 Port flush  input  1  synchronous abort of the operation in flight.
REQ-007 Port gnt  output  4  one-hot grant, one-cycle pulse.
REQ-008 Port busy  output  1  high when state is not IDLE.
REQ-009 Port done  output  1  one-cycle pulse, product valid.
REQ-010 Port done_id  output  2  index of the requester owning the product.
REQ-011 Port product  output  32  unsigned a*b, full width, no truncation.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY and DONE; it SHALL be one-hot or binary, and the encoding SHALL be invisible at the ports.
REQ-013 In IDLE with any req bit high, at edge E0 the block SHALL select a winner by round-robin, capture areg/breg from the winner's operands, clear acc, set cnt=0, pulse the winner's gnt bit for the cycle after E0, and enter BUSY.
REQ-014 The round-robin search SHALL start at (last_winner+1) mod 4, and last_winner SHALL update on each grant.
REQ-015 The block SHALL sample req only in IDLE; req bits in BUSY/DONE SHALL be ignored and SHALL NOT be lost while they stay high.
REQ-016 Each BUSY edge SHALL perform one iteration: if areg[0], acc += breg (32-bit); areg >>= 1; breg <<= 1; cnt += 1.
REQ-017 When the edge completes iteration cnt=15, the FSM SHALL load product from the final acc and enter DONE.
REQ-018 In DONE, done SHALL be 1 and done_id SHALL equal the winner index for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-019 Latency without early termination SHALL be: gnt in cycle E0+1, done in the cycle after E16; the next grant SHALL be no earlier than E18 (18-cycle throughput).
REQ-020 product SHALL hold its value until the next done and SHALL NOT change in any other cycle.
REQ-021 flush=1 in BUSY or DONE SHALL return the FSM to IDLE at the next edge; done SHALL NOT be asserted and product SHALL be unchanged.
REQ-022 flush in IDLE SHALL suppress arbitration at that edge.
REQ-023 flush coinciding with the final iteration edge SHALL take priority: no product update and no done.
REQ-024 Operands 0 or 0xFFFF SHALL be handled exactly: 0xFFFF*0xFFFF=0xFFFE0001 with no overflow.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=IDLE, gnt=0, busy=0, done=0, done_id=0, product=0, acc/areg/breg/cnt=0, last_winner=3 (so requester 0 wins first).
REQ-026 Reset mid-operation SHALL discard the operation without a done pulse.
REQ-027 The first arbitration SHALL occur on the first edge after rst_n deasserts.

Configuration
REQ-028 The macro FFT_MULT_SCHED_EARLY_EN SHALL control early termination.
REQ-029 With FFT_MULT_SCHED_EARLY_EN defined, a BUSY edge that sees areg==0 SHALL load product from acc and enter DONE without iterating.
REQ-030 With FFT_MULT_SCHED_EARLY_EN defined, the minimum latency SHALL be done in the cycle after E1 (a=0).
REQ-031 With FFT_MULT_SCHED_EARLY_EN undefined, the block SHALL always run exactly 16 iterations.
REQ-032 Product values SHALL be identical with and without FFT_MULT_SCHED_EARLY_EN.

Verification
REQ-033 Single op: req=0001, a0=3, b0=5 -> gnt=0001 at E0+1, done after E16, done_id=0, product=15.
REQ-034 Max operands: a2=b2=0xFFFF -> product=0xFFFE0001, done_id=2.
REQ-035 Fairness: req=1111 held, each req dropped on its gnt -> grant order 0,1,2,3, 18 cycles apart.
REQ-036 Flush: flush pulsed at E8 of an op with a1=7, b1=9 -> no done, busy=0 after the next edge, product keeps its prior value.
REQ-037 Reset mid-op: rst_n low at E5 -> all outputs 0 asynchronously; after release, req=1000 -> requester 3 granted.
REQ-038 FFT_MULT_SCHED_EARLY_EN: a0=0, b0=0x1234 -> done after E1, product=0; a0=1, b0=0x1234 -> done after E2, product=0x1234.
